// File: rtl/hazard_scoreboard_if.sv
// Decoder <-> hazard scoreboard bundle: ID-stage operands in, per-stage write tags and stall out.
// stall_count exists only when HAZARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
  parameter int REGW = 5
);
  typedef logic [REGW-1:0] regbits_t;

  logic     advance;
  logic     flush;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     id_uses_rs;
  logic     id_uses_rt;
  logic     id_wr_en;
  regbits_t id_wr_reg;
  logic     id_is_load;

  regbits_t reg_wr_ex;
  regbits_t reg_wr_mem;
  regbits_t reg_wr_wb;
  logic     ex_is_load;
  logic     stall;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
`endif

  modport master (
    output advance, flush, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wr_en, id_wr_reg, id_is_load,
    input  reg_wr_ex, reg_wr_mem, reg_wr_wb, ex_is_load, stall
`ifdef HAZARD_STATS_EN
    , input stall_count
`endif
  );

  modport slave (
    input  advance, flush, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wr_en, id_wr_reg, id_is_load,
    output reg_wr_ex, reg_wr_mem, reg_wr_wb, ex_is_load, stall
`ifdef HAZARD_STATS_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB destination-tag tracker with load-use stall; tags appear 1/2/3 advancing cycles after ID,
// stall is combinational and slots hold while advance=0. Optional HAZARD_STATS_EN adds a saturating stall counter.
module hazard_scoreboard #(
  parameter int REGW = 5
) (
  input logic              CLK,
  input logic              RST,
  hazard_scoreboard_if.slave sb
);
  typedef logic [REGW-1:0] regbits_t;

  typedef struct packed {
    logic     valid;
    regbits_t tag;
    logic     is_load;
  } slot_t;

  slot_t ex_slot;
  slot_t mem_slot;
  slot_t wb_slot;
  slot_t id_slot;

  logic rs_hit;
  logic rt_hit;
  logic stall_int;

  assign rs_hit = sb.id_uses_rs && (sb.id_rs == ex_slot.tag);
  assign rt_hit = sb.id_uses_rt && (sb.id_rt == ex_slot.tag);

  // Only a load still in EX is uncoverable; MEM/WB producers are forwarded.
  assign stall_int = !sb.flush && ex_slot.valid && ex_slot.is_load && (rs_hit || rt_hit);

  // $0 is never tracked, so a write to it enters as an invalid slot.
  always_comb begin
    id_slot         = '0;
    id_slot.valid   = sb.id_wr_en && (sb.id_wr_reg != '0);
    id_slot.tag     = sb.id_wr_reg;
    id_slot.is_load = sb.id_is_load;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else if (sb.advance) begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      ex_slot  <= (stall_int || sb.flush) ? slot_t'('0) : id_slot;
    end
  end

  assign sb.reg_wr_ex  = ex_slot.valid  ? ex_slot.tag  : '0;
  assign sb.reg_wr_mem = mem_slot.valid ? mem_slot.tag : '0;
  assign sb.reg_wr_wb  = wb_slot.valid  ? wb_slot.tag  : '0;
  assign sb.ex_is_load = ex_slot.valid && ex_slot.is_load;
  assign sb.stall      = stall_int;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (stall_int && sb.advance && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign sb.stall_count = stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: directed vector table, reset-mid-stall sequence, random run against a pipeline-list model.
module tb_hazard_scoreboard;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   tests = 0;
  int   fails = 0;

  hazard_scoreboard_if #(.REGW(5)) sb ();
  hazard_scoreboard #(.REGW(5)) dut (.CLK(CLK), .RST(RST), .sb(sb));

  always #5 CLK = ~CLK;

  typedef struct {
    bit adv, fl;
    int rs, rt;
    bit urs, urt, wen;
    int wr;
    bit ld;
    bit e_st;
    int e_ex, e_mem, e_wb;
    bit e_ld;
  } vec_t;

  vec_t vt[$];

  // Model: the three in-flight instructions, index 0 = EX. tag 0 means no tracked write.
  int pipe_tag[3];
  bit pipe_ld[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit adv, bit fl, int rs, int rt, bit urs, bit urt, bit wen,
                              int wr, bit ld, bit st, int ex, int mem, int wb, bit eld);
    vec_t v;
    v.adv = adv; v.fl = fl; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.wen = wen; v.wr = wr; v.ld = ld; v.e_st = st;
    v.e_ex = ex; v.e_mem = mem; v.e_wb = wb; v.e_ld = eld;
    return v;
  endfunction

  task automatic drive(bit adv, bit fl, int rs, int rt, bit urs, bit urt, bit wen, int wr, bit ld);
    sb.advance    = adv;
    sb.flush      = fl;
    sb.id_rs      = 5'(rs);
    sb.id_rt      = 5'(rt);
    sb.id_uses_rs = urs;
    sb.id_uses_rt = urt;
    sb.id_wr_en   = wen;
    sb.id_wr_reg  = 5'(wr);
    sb.id_is_load = ld;
  endtask

  function automatic bit model_stall();
    if (sb.flush || pipe_tag[0] == 0 || !pipe_ld[0]) return 1'b0;
    return (sb.id_uses_rs && int'(sb.id_rs) == pipe_tag[0]) ||
           (sb.id_uses_rt && int'(sb.id_rt) == pipe_tag[0]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      pipe_tag[i] = 0;
      pipe_ld[i]  = 1'b0;
    end
  endtask

  task automatic model_step(bit st);
    pipe_tag[2] = pipe_tag[1]; pipe_ld[2] = pipe_ld[1];
    pipe_tag[1] = pipe_tag[0]; pipe_ld[1] = pipe_ld[0];
    if (st || sb.flush || !sb.id_wr_en || sb.id_wr_reg == 0) begin
      pipe_tag[0] = 0; pipe_ld[0] = 1'b0;
    end else begin
      pipe_tag[0] = int'(sb.id_wr_reg); pipe_ld[0] = sb.id_is_load;
    end
  endtask

  initial begin
    int exp_cnt;
    bit st;
    exp_cnt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          adv fl rs rt urs urt wen wr ld | st ex mem wb ld
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 1, 2, 1, 1, 1, 5, 0,  0, 5, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 5, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 5, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8, 1,  0, 8, 0, 0, 1));
    vt.push_back(mk(1, 0, 8, 3, 1, 1, 1, 9, 0,  1, 0, 8, 0, 0));
    vt.push_back(mk(1, 0, 8, 3, 1, 1, 1, 9, 0,  0, 9, 0, 8, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8, 1,  0, 8, 9, 0, 1));
    vt.push_back(mk(1, 1, 8, 0, 1, 0, 1, 7, 0,  0, 0, 8, 9, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 8, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 1, 4, 0,  0, 4, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8, 1,  0, 8, 4, 0, 1));
    vt.push_back(mk(0, 0, 0, 8, 0, 1, 1, 6, 0,  1, 8, 4, 0, 1));
    vt.push_back(mk(0, 0, 0, 8, 0, 1, 1, 6, 0,  1, 8, 4, 0, 1));
    vt.push_back(mk(0, 0, 0, 8, 0, 1, 1, 6, 0,  1, 8, 4, 0, 1));
    vt.push_back(mk(1, 0, 0, 8, 0, 1, 1, 6, 0,  1, 0, 8, 4, 0));
    vt.push_back(mk(1, 0, 0, 8, 0, 1, 1, 6, 0,  0, 6, 0, 8, 0));
    vt.push_back(mk(1, 0, 6, 6, 1, 1, 0, 0, 0,  0, 0, 6, 0, 0));

    // Reset with advance high: must still clear everything.
    drive(1, 0, 0, 0, 0, 0, 1, 3, 1);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_ex", sb.reg_wr_ex, 0);
    chk("reset_mem", sb.reg_wr_mem, 0);
    chk("reset_wb", sb.reg_wr_wb, 0);
    chk("reset_ex_is_load", sb.ex_is_load, 0);
    chk("reset_stall", sb.stall, 0);
`ifdef HAZARD_STATS_EN
    chk("reset_stall_count", sb.stall_count, 0);
`endif

    foreach (vt[i]) begin
      drive(vt[i].adv, vt[i].fl, vt[i].rs, vt[i].rt, vt[i].urs, vt[i].urt,
            vt[i].wen, vt[i].wr, vt[i].ld);
      #1;
      chk($sformatf("vec%0d_stall", i), sb.stall, vt[i].e_st);
      if (vt[i].e_st && vt[i].adv) exp_cnt++;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_ex", i), sb.reg_wr_ex, vt[i].e_ex);
      chk($sformatf("vec%0d_mem", i), sb.reg_wr_mem, vt[i].e_mem);
      chk($sformatf("vec%0d_wb", i), sb.reg_wr_wb, vt[i].e_wb);
      chk($sformatf("vec%0d_ex_is_load", i), sb.ex_is_load, vt[i].e_ld);
    end
`ifdef HAZARD_STATS_EN
    chk("table_stall_count", sb.stall_count, exp_cnt);
`endif

    // Reset in the middle of a load-use stall.
    drive(1, 0, 0, 0, 0, 0, 1, 8, 1);
    @(posedge CLK); #1;
    drive(1, 0, 8, 0, 1, 0, 1, 2, 0);
    #1 chk("pre_reset_stall", sb.stall, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("post_reset_stall", sb.stall, 0);
    chk("post_reset_ex", sb.reg_wr_ex, 0);
    chk("post_reset_mem", sb.reg_wr_mem, 0);
`ifdef HAZARD_STATS_EN
    chk("post_reset_count", sb.stall_count, 0);
`endif

    // Random run with a small register range so hazards are frequent.
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1));
      RST = ($urandom_range(0, 63) == 0);
      #1;
      st = model_stall();
      chk("rnd_stall", sb.stall, st);
      @(posedge CLK);
      if (RST) model_clear();
      else if (sb.advance) model_step(st);
      #1;
      RST = 1'b0;
      chk("rnd_ex", sb.reg_wr_ex, pipe_tag[0]);
      chk("rnd_mem", sb.reg_wr_mem, pipe_tag[1]);
      chk("rnd_wb", sb.reg_wr_wb, pipe_tag[2]);
      chk("rnd_ex_is_load", sb.ex_is_load, pipe_tag[0] != 0 && pipe_ld[0]);
    end

`ifdef HAZARD_STATS_EN
    // Saturation: a load enters EX, then the dependent instruction stalls; repeat.
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int n = 0; n < 65540; n++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 8, 1);
      @(posedge CLK); #1;
      drive(1, 0, 8, 0, 1, 0, 0, 0, 0);
      @(posedge CLK); #1;
    end
    chk("sat_stall_count", sb.stall_count, 16'hFFFF);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("sat_cleared", sb.stall_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
